// File: rtl/switch_allocator.sv
// Per-outport wormhole allocator: round-robin arbitration among input buffers,
// then locks the winning buffer onto the outport for the packet's flit count.
module switch_allocator #(
  parameter int NUM_BUFFERS  = 4,
  parameter int NUM_OUTPORTS = 4,
  parameter int LEN_W        = 8
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic [NUM_BUFFERS-1:0]                     req_valid,
  input  logic [NUM_BUFFERS*$clog2(NUM_OUTPORTS)-1:0] req_outport,
  input  logic [NUM_BUFFERS*LEN_W-1:0]               req_len,
  input  logic [NUM_OUTPORTS-1:0]                    flit_sent,
  output logic [NUM_OUTPORTS*$clog2(NUM_BUFFERS)-1:0] out_sel,
  output logic [NUM_OUTPORTS-1:0]                    out_valid,
  output logic [NUM_BUFFERS-1:0]                     grant,
  output logic [NUM_BUFFERS-1:0]                     busy
);

  localparam int OP_W  = $clog2(NUM_OUTPORTS);
  localparam int BUF_W = $clog2(NUM_BUFFERS);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state_r     [NUM_OUTPORTS];
  state_t            state_s     [NUM_OUTPORTS];
  logic [BUF_W-1:0]  rr_ptr_r    [NUM_OUTPORTS];
  logic [BUF_W-1:0]  rr_ptr_s    [NUM_OUTPORTS];
  logic [LEN_W-1:0]  remaining_r [NUM_OUTPORTS];
  logic [LEN_W-1:0]  remaining_s [NUM_OUTPORTS];
  logic [BUF_W-1:0]  sel_r       [NUM_OUTPORTS];
  logic [BUF_W-1:0]  sel_s       [NUM_OUTPORTS];
  logic [NUM_BUFFERS-1:0] cand_s [NUM_OUTPORTS];
  logic              win_found_s [NUM_OUTPORTS];
  logic [BUF_W-1:0]  win_idx_s   [NUM_OUTPORTS];
  logic [NUM_BUFFERS-1:0] grant_r, grant_s;
  logic [NUM_BUFFERS-1:0] busy_r, busy_s;

  // Buffer index reached after stepping off positions from base, wrapping at NUM_BUFFERS
  function automatic int wrap_idx(input int base, input int off);
    int sum;
    sum = base + off;
    return (sum >= NUM_BUFFERS) ? (sum - NUM_BUFFERS) : sum;
  endfunction

  // Candidate mask per outport: valid, targeting this outport, and not already busy
  always_comb begin
    for (int p = 0; p < NUM_OUTPORTS; p++) begin
      for (int b = 0; b < NUM_BUFFERS; b++) begin
        cand_s[p][b] = req_valid[b] && !busy_r[b] &&
                       (req_outport[b*OP_W +: OP_W] == OP_W'(p));
      end
    end
  end

  // Round-robin search from rr_ptr; the first hit in search order wins
  always_comb begin
    for (int p = 0; p < NUM_OUTPORTS; p++) begin
      win_found_s[p] = 1'b0;
      win_idx_s[p]   = '0;
      for (int off = 0; off < NUM_BUFFERS; off++) begin
        win_idx_s[p]   = (cand_s[p][wrap_idx(int'(rr_ptr_r[p]), off)] && !win_found_s[p])
                         ? BUF_W'(wrap_idx(int'(rr_ptr_r[p]), off)) : win_idx_s[p];
        win_found_s[p] = win_found_s[p] | cand_s[p][wrap_idx(int'(rr_ptr_r[p]), off)];
      end
    end
  end

  // Per-outport IDLE/LOCKED next state, lock bookkeeping and grant/busy updates
  always_comb begin
    grant_s = '0;
    busy_s  = busy_r;
    for (int p = 0; p < NUM_OUTPORTS; p++) begin
      state_s[p]     = state_r[p];
      rr_ptr_s[p]    = rr_ptr_r[p];
      remaining_s[p] = remaining_r[p];
      sel_s[p]       = sel_r[p];
      case (state_r[p])
        IDLE: begin
          if (win_found_s[p]) begin
            state_s[p]     = LOCKED;
            sel_s[p]       = win_idx_s[p];
            remaining_s[p] = (req_len[int'(win_idx_s[p])*LEN_W +: LEN_W] == '0)
                             ? LEN_W'(1) : req_len[int'(win_idx_s[p])*LEN_W +: LEN_W];
            rr_ptr_s[p]    = (win_idx_s[p] == BUF_W'(NUM_BUFFERS-1))
                             ? '0 : win_idx_s[p] + BUF_W'(1);
            grant_s[win_idx_s[p]] = 1'b1;
            busy_s[win_idx_s[p]]  = 1'b1;
          end else begin
            state_s[p] = IDLE;
          end
        end
        LOCKED: begin
          // Requests are not arbitrated while locked, so release leaves a one-cycle bubble
          if (flit_sent[p]) begin
            remaining_s[p] = remaining_r[p] - LEN_W'(1);
            if (remaining_r[p] == LEN_W'(1)) begin
              state_s[p]         = IDLE;
              busy_s[sel_r[p]]   = 1'b0;
            end else begin
              state_s[p] = LOCKED;
            end
          end else begin
            state_s[p] = LOCKED;
          end
        end
        default: begin
          state_s[p] = IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset drops every lock
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int p = 0; p < NUM_OUTPORTS; p++) begin
        state_r[p]     <= IDLE;
        rr_ptr_r[p]    <= '0;
        remaining_r[p] <= '0;
        sel_r[p]       <= '0;
      end
      grant_r <= '0;
      busy_r  <= '0;
    end else begin
      for (int p = 0; p < NUM_OUTPORTS; p++) begin
        state_r[p]     <= state_s[p];
        rr_ptr_r[p]    <= rr_ptr_s[p];
        remaining_r[p] <= remaining_s[p];
        sel_r[p]       <= sel_s[p];
      end
      grant_r <= grant_s;
      busy_r  <= busy_s;
    end
  end

  assign grant = grant_r;
  assign busy  = busy_r;

  for (genvar g = 0; g < NUM_OUTPORTS; g++) begin : g_out
    assign out_sel[g*BUF_W +: BUF_W] = sel_r[g];
    assign out_valid[g]              = (state_r[g] == LOCKED);
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench: 4x4 allocator driven from a cycle-by-cycle vector table plus
// hand sequences; a 3x3 instance covers wrap-around and out-of-range outports.
module tb_switch_allocator;

  logic        CLK;
  logic        RST;

  logic [3:0]  a_rv, a_fs, a_grant, a_busy, a_ov;
  logic [7:0]  a_ro, a_os;
  logic [31:0] a_rl;

  logic [2:0]  b_rv, b_fs, b_grant, b_busy, b_ov;
  logic [5:0]  b_ro, b_os;
  logic [23:0] b_rl;

  int n_cmp = 0;
  int n_err = 0;

  switch_allocator #(.NUM_BUFFERS(4), .NUM_OUTPORTS(4), .LEN_W(8)) dut_a (
    .CLK(CLK), .RST(RST), .req_valid(a_rv), .req_outport(a_ro), .req_len(a_rl),
    .flit_sent(a_fs), .out_sel(a_os), .out_valid(a_ov), .grant(a_grant), .busy(a_busy)
  );

  switch_allocator #(.NUM_BUFFERS(3), .NUM_OUTPORTS(3), .LEN_W(8)) dut_b (
    .CLK(CLK), .RST(RST), .req_valid(b_rv), .req_outport(b_ro), .req_len(b_rl),
    .flit_sent(b_fs), .out_sel(b_os), .out_valid(b_ov), .grant(b_grant), .busy(b_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  rv;
    logic [7:0]  ro;
    logic [31:0] rl;
    logic [3:0]  fs;
    logic [3:0]  grant;
    logic [3:0]  busy;
    logic [3:0]  ov;
    logic [7:0]  os;
  } vec_t;

  vec_t vecs [15];
  logic [1:0] rr_order [6];
  logic [3:0] one_hot;

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // rv, ro, rl, fs | grant, busy, out_valid, out_sel
    vecs[0]  = '{4'b0100, 8'h10, 32'h0003_0000, 4'b0000, 4'b0100, 4'b0100, 4'b0010, 8'h08};
    vecs[1]  = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0100, 4'b0010, 8'h08};
    vecs[2]  = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0010, 4'b0000, 4'b0100, 4'b0010, 8'h08};
    vecs[3]  = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0010, 4'b0000, 4'b0100, 4'b0010, 8'h08};
    vecs[4]  = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 8'h08};
    vecs[5]  = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 8'h08};
    vecs[6]  = '{4'b0011, 8'h0E, 32'h0000_0205, 4'b0000, 4'b0011, 4'b0011, 4'b1100, 8'h48};
    vecs[7]  = '{4'b0000, 8'h00, 32'h0000_0000, 4'b1100, 4'b0000, 4'b0011, 4'b1100, 8'h48};
    vecs[8]  = '{4'b0000, 8'h00, 32'h0000_0000, 4'b1100, 4'b0000, 4'b0001, 4'b0100, 8'h48};
    vecs[9]  = '{4'b1000, 8'h80, 32'h0000_0000, 4'b0100, 4'b0000, 4'b0001, 4'b0100, 8'h48};
    vecs[10] = '{4'b1000, 8'h80, 32'h0000_0000, 4'b0100, 4'b0000, 4'b0001, 4'b0100, 8'h48};
    vecs[11] = '{4'b1000, 8'h80, 32'h0000_0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 8'h48};
    vecs[12] = '{4'b1000, 8'h80, 32'h0000_0000, 4'b0000, 4'b1000, 4'b1000, 4'b0100, 8'h78};
    vecs[13] = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0000, 4'b0000, 4'b1000, 4'b0100, 8'h78};
    vecs[14] = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 8'h78};
    rr_order = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

    a_rv = '0; a_ro = '0; a_rl = '0; a_fs = '0;
    b_rv = '0; b_ro = '0; b_rl = '0; b_fs = '0;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;

    check("rst a grant", a_grant, 4'b0000);
    check("rst a busy",  a_busy,  4'b0000);
    check("rst a ov",    a_ov,    4'b0000);
    check("rst a os",    a_os,    8'h00);
    check("rst b grant", b_grant, 3'b000);
    check("rst b ov",    b_ov,    3'b000);

    // single packet, parallel outports, len 0, request colliding with release
    for (int i = 0; i < 15; i++) begin
      a_rv = vecs[i].rv; a_ro = vecs[i].ro; a_rl = vecs[i].rl; a_fs = vecs[i].fs;
      step();
      check($sformatf("v%0d grant", i), a_grant, vecs[i].grant);
      check($sformatf("v%0d busy", i),  a_busy,  vecs[i].busy);
      check($sformatf("v%0d ov", i),    a_ov,    vecs[i].ov);
      check($sformatf("v%0d os", i),    a_os,    vecs[i].os);
    end
    a_rv = '0; a_ro = '0; a_rl = '0; a_fs = '0;
    step();

    // round-robin on outport 0 among buffers 0, 1, 3 with len 1
    a_rv = 4'b1011; a_ro = 8'h00; a_rl = 32'h0101_0101; a_fs = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      step();
      one_hot = 4'b0001 << rr_order[i];
      check($sformatf("rr%0d grant", i), a_grant, one_hot);
      check($sformatf("rr%0d sel", i),   a_os[1:0], rr_order[i]);
      step();
      check($sformatf("rr%0d release ov", i), a_ov[0], 1'b0);
      check($sformatf("rr%0d bubble grant", i), a_grant, 4'b0000);
    end
    a_rv = '0; a_fs = '0;
    step();

    // reset mid-packet after moving rr_ptr of outport 3 to 2
    a_rv = 4'b0010; a_ro = 8'h0C; a_rl = 32'h0000_0500;
    step();
    check("pre-rst grant", a_grant, 4'b0010);
    check("pre-rst ov",    a_ov,    4'b1000);
    a_rv = '0;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    check("mid-rst grant", a_grant, 4'b0000);
    check("mid-rst busy",  a_busy,  4'b0000);
    check("mid-rst ov",    a_ov,    4'b0000);
    check("mid-rst os",    a_os,    8'h00);
    a_rv = 4'b0101; a_ro = 8'h33; a_rl = 32'h0001_0001;
    step();
    check("post-rst grant", a_grant, 4'b0001);
    check("post-rst sel",   a_os[7:6], 2'd0);
    check("post-rst busy",  a_busy, 4'b0001);
    a_rv = '0; a_fs = 4'b1000;
    step();
    check("post-rst release", a_ov, 4'b0000);
    a_fs = '0;

    // 3x3: outport 3 is out of range and must never be granted
    b_rv = 3'b010; b_ro = 6'h0C; b_rl = 24'h01_0101;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("oor%0d grant", i), b_grant, 3'b000);
      check($sformatf("oor%0d busy", i),  b_busy,  3'b000);
    end

    // 3x3 wrap: buffer 1 wins first so rr_ptr becomes 2, then 2 wins over 0, then 0
    b_ro = 6'h00;
    step();
    check("wrap g1", b_grant, 3'b010);
    check("wrap s1", b_os[1:0], 2'd1);
    b_rv = 3'b000; b_fs = 3'b001;
    step();
    check("wrap rel1", b_ov[0], 1'b0);
    b_fs = 3'b000; b_rv = 3'b101;
    step();
    check("wrap g2", b_grant, 3'b100);
    check("wrap s2", b_os[1:0], 2'd2);
    b_rv = 3'b000; b_fs = 3'b001;
    step();
    check("wrap rel2 busy", b_busy, 3'b000);
    b_fs = 3'b000; b_rv = 3'b101;
    step();
    check("wrap g3", b_grant, 3'b001);
    check("wrap s3", b_os[1:0], 2'd0);
    b_rv = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
